puf_response_collector: RTL and testbench
=========================================

Name: puf_response_collector

Overview:
- Consumes the per-loop count stream produced by the PUF top: `store_response_puf` strobe, `loop_number`, `loop_response`.
- Compares adjacent loop pairs (2k vs 2k+1) to form one response bit per pair.
- Packs the bits into words and delivers them over a valid/ready output stream with a small FIFO.
- Sits between the PUF top and the host/UART link.

Parameters:
- NUM_LOOPS, 1280: loops scanned per run; must be even; pairs = NUM_LOOPS/2.
- TOT_CNT_BITS, 32: width of `loop_response`.
- WORD_BITS, 32: output word width.
- FIFO_DEPTH, 4: output FIFO depth in words; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a collection run.
- store_response_puf  in  1  one-cycle strobe; `loop_number`/`loop_response` valid.
- loop_number  in  $clog2(NUM_LOOPS-1)+1  index of the loop being reported.
- loop_response  in  TOT_CNT_BITS  count for that loop.
- puf_done  in  1  PUF run finished (level or pulse).
- out_data  out  WORD_BITS  packed response word, LSB = lowest pair index.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts `out_data` when `out_valid` && `out_ready`.
- out_last  out  1  qualifies the final word of the run.
- busy  out  1  high in any state other than IDLE or DONE.
- seq_error  out  1  sticky: sequence or early-done fault.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (`reset`=0 at a rising `clk`):
  - state = IDLE; FIFO emptied.
  - All outputs 0.
  - bit_cnt = 0, pair_cnt = 0, word_cnt = 0, shift register = 0.
- States: IDLE, WAIT_A, WAIT_B, FLUSH, DONE.
- IDLE:
  - On `start`: clear sticky flags and counters, go to WAIT_A.
  - Strobes and `puf_done` are ignored.
- WAIT_A, on strobe:
  - If `loop_number` == 2*pair_cnt: latch count_a, go to WAIT_B.
  - Otherwise set `seq_error` and stay.
- WAIT_B, on strobe:
  - If `loop_number` == 2*pair_cnt+1:
    - bit = (loop_response > count_a) unsigned; equal gives 0.
    - Write bit at position bit_cnt; pair_cnt++; bit_cnt++; go to WAIT_A.
  - Otherwise set `seq_error`, discard count_a, go to WAIT_A without consuming the pair.
- Word completion:
  - When bit_cnt reaches WORD_BITS, or the final pair (pair_cnt becomes NUM_LOOPS/2) completes, push {last, word} into the FIFO on the same edge the bit is registered.
  - Clear shift register and bit_cnt; word_cnt++.
  - last = 1 iff pair_cnt == NUM_LOOPS/2.
  - Partial final words are zero-padded in the upper bits.
- Latency: the B strobe in cycle N gives `out_valid` high in cycle N+1 when the FIFO was empty (first-word fall-through).
- After the final pair: go to DONE.
- `puf_done` while in WAIT_A/WAIT_B with pair_cnt < NUM_LOOPS/2:
  - Set `seq_error` and go to FLUSH.
  - FLUSH pushes the current partial word (all zeros if bit_cnt = 0) with last = 1, then goes to DONE.
  - If the FIFO is full, FLUSH waits (it does not drop the word).
- FIFO full at a normal word push: drop the word, set `overflow`.
- DONE:
  - Stay until the FIFO has drained and `start` is seen; then behave as IDLE `start`.
  - `start` while the FIFO is non-empty is ignored.
- Simultaneous events:
  - Strobe and `puf_done` in the same cycle: process the strobe first; evaluate `puf_done` against the updated pair_cnt.
  - FIFO push and pop in the same cycle when full: both are allowed, no overflow.
- `start` while `busy` is ignored.
- Reset mid-run: all in-flight data is lost, outputs return to reset values.
- `out_data`/`out_last` must be held stable while `out_valid` && !`out_ready`.

Decomposition:
- Package `puf_pkg`:
  - `collector_state_t` enum.
  - Function `loop_idx_bits(NUM_LOOPS)` = $clog2(NUM_LOOPS-1)+1.
  - Constant NUM_PAIRS = NUM_LOOPS/2.
- Sub-module `puf_resp_fifo`:
  - Synchronous FWFT FIFO, width WORD_BITS+1 (data + last), parameter FIFO_DEPTH.
  - Ports: push/full, pop/empty.
  - Active-low synchronous reset.

Test Plan:
- All scenarios use NUM_LOOPS=16, WORD_BITS=4, FIFO_DEPTH=2, `out_ready`=1 unless stated.
- Monotonic counts: `start`, then loops 0..15 with response = 100+i → two words 4'hF, 4'hF, second with `out_last`=1; `seq_error`=0; `busy` drops after loop 15.
- Mixed pattern: pairs where odd > even for pairs 0,2,5,7 only; pair 3 has equal counts → words 4'h5, 4'hA.
- Sequence fault: loop 1 sent before loop 0 → `seq_error`=1. Then 0..15 correctly → words still 4'hF, 4'hF.
- Early done: `puf_done` after loop 5 (3 pairs, all 1) → single word 4'h7 with `out_last`=1; `seq_error`=1.
- Backpressure/overflow: `out_ready`=0, NUM_LOOPS=32 (4 words) → first two words held stable, `overflow`=1. Raise `out_ready` → words 1 and 2 delivered in order.
- Reset mid-run: `reset`=0 for one cycle after loop 6 → all outputs 0, FIFO empty, subsequent `start` and a full run produce correct words.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the PUF response collector.
package puf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitA,
    StWaitB,
    StFlush,
    StDone
  } collector_state_t;

  function automatic int unsigned loop_idx_bits(int unsigned num_loops);
    return $clog2(num_loops - 1) + 1;
  endfunction

  function automatic int unsigned num_pairs(int unsigned num_loops);
    return num_loops / 2;
  endfunction

endpackage

// File: rtl/puf_resp_fifo.sv
// First-word-fall-through FIFO holding packed response words plus their last flag.
module puf_resp_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head is leaving on the same edge.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// Turns per-loop PUF counts into response bits (pair 2k vs 2k+1), packs them into words
// and streams the words out through a small FWFT FIFO.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int unsigned NUM_LOOPS    = 1280,
  parameter int unsigned TOT_CNT_BITS = 32,
  parameter int unsigned WORD_BITS    = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                store_response_puf,
  input  logic [loop_idx_bits(NUM_LOOPS)-1:0] loop_number,
  input  logic [TOT_CNT_BITS-1:0]             loop_response,
  input  logic                                puf_done,
  output logic [WORD_BITS-1:0]                out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                seq_error,
  output logic                                overflow
);

  localparam int unsigned IdxW      = loop_idx_bits(NUM_LOOPS);
  localparam int unsigned NUM_PAIRS = num_pairs(NUM_LOOPS);
  localparam int unsigned PairW     = $clog2(NUM_PAIRS + 1);
  localparam int unsigned BitW      = $clog2(WORD_BITS + 1);

  collector_state_t        state_q, state_d;
  logic [PairW-1:0]        pair_cnt_q, pair_cnt_d;
  logic [BitW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0]    shift_q, shift_d;
  logic [TOT_CNT_BITS-1:0] count_a_q, count_a_d;
  logic                    seq_error_q, seq_error_d;
  logic                    overflow_q, overflow_d;

  logic [IdxW-1:0]      idx_a, idx_b;
  logic [PairW-1:0]     pair_cnt_inc;
  logic [BitW-1:0]      bit_cnt_inc;
  logic                 resp_bit, final_pair, can_push;
  logic [WORD_BITS-1:0] new_shift;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, push_last;
  logic [WORD_BITS-1:0] push_word;
  logic [WORD_BITS:0]   fifo_rdata;

  assign idx_a        = IdxW'({pair_cnt_q, 1'b0});
  assign idx_b        = idx_a | IdxW'(1);
  assign pair_cnt_inc = pair_cnt_q + PairW'(1);
  assign bit_cnt_inc  = bit_cnt_q + BitW'(1);
  assign final_pair   = (pair_cnt_inc == PairW'(NUM_PAIRS));
  assign resp_bit     = (loop_response > count_a_q);
  assign new_shift    = shift_q | (WORD_BITS'(resp_bit) << bit_cnt_q);
  assign can_push     = !fifo_full || fifo_pop;

  always_comb begin
    state_d     = state_q;
    pair_cnt_d  = pair_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    count_a_d   = count_a_q;
    seq_error_d = seq_error_q;
    overflow_d  = overflow_q;
    fifo_push   = 1'b0;
    push_last   = 1'b0;
    push_word   = shift_q;

    unique case (state_q)
      // The FIFO is always empty in StIdle, so one condition covers both states.
      StIdle, StDone: begin
        if (start && fifo_empty) begin
          state_d     = StWaitA;
          pair_cnt_d  = '0;
          bit_cnt_d   = '0;
          shift_d     = '0;
          count_a_d   = '0;
          seq_error_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      StWaitA: begin
        if (store_response_puf) begin
          if (loop_number == idx_a) begin
            count_a_d = loop_response;
            state_d   = StWaitB;
          end else begin
            seq_error_d = 1'b1;
          end
        end
      end
      StWaitB: begin
        if (store_response_puf) begin
          if (loop_number == idx_b) begin
            pair_cnt_d = pair_cnt_inc;
            if ((bit_cnt_inc == BitW'(WORD_BITS)) || final_pair) begin
              push_word  = new_shift;
              push_last  = final_pair;
              fifo_push  = can_push;
              overflow_d = overflow_q | !can_push;
              shift_d    = '0;
              bit_cnt_d  = '0;
            end else begin
              shift_d   = new_shift;
              bit_cnt_d = bit_cnt_inc;
            end
            state_d = final_pair ? StDone : StWaitA;
          end else begin
            seq_error_d = 1'b1;
            state_d     = StWaitA;
          end
        end
      end
      StFlush: begin
        push_last = 1'b1;
        if (can_push) begin
          fifo_push = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Early done is judged after any same-cycle strobe has been applied.
    if (puf_done && (state_q == StWaitA || state_q == StWaitB) &&
        (state_d == StWaitA || state_d == StWaitB)) begin
      seq_error_d = 1'b1;
      state_d     = StFlush;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      pair_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      count_a_q   <= '0;
      seq_error_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_cnt_q  <= pair_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      count_a_q   <= count_a_d;
      seq_error_q <= seq_error_d;
      overflow_q  <= overflow_d;
    end
  end

  puf_resp_fifo #(
    .Width(WORD_BITS + 1),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (fifo_push),
    .data_i ({push_last, push_word}),
    .full_o (fifo_full),
    .pop_i  (fifo_pop),
    .data_o (fifo_rdata),
    .empty_o(fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign out_data  = fifo_rdata[WORD_BITS-1:0];
  assign out_last  = fifo_rdata[WORD_BITS];
  assign busy      = !(state_q == StIdle || state_q == StDone);
  assign seq_error = seq_error_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench: a 16-loop collector (4-bit words, 2-deep FIFO) and a 32-loop one for overflow.
module tb_puf_response_collector;

  logic        clk = 1'b0;
  logic        reset, start, store, puf_done;
  logic [5:0]  loop_number;
  logic [31:0] loop_response;

  logic [3:0] a_data, b_data;
  logic       a_valid, a_ready, a_last, a_busy, a_seq, a_ovf;
  logic       b_valid, b_ready, b_last, b_busy, b_seq, b_ovf;

  int checks = 0;
  int passes = 0;

  logic [4:0] qa[$];
  logic [4:0] qb[$];

  always #5 clk = ~clk;

  puf_response_collector #(
    .NUM_LOOPS(16), .TOT_CNT_BITS(32), .WORD_BITS(4), .FIFO_DEPTH(2)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .store_response_puf(store),
    .loop_number(loop_number[4:0]), .loop_response(loop_response), .puf_done(puf_done),
    .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready), .out_last(a_last),
    .busy(a_busy), .seq_error(a_seq), .overflow(a_ovf)
  );

  puf_response_collector #(
    .NUM_LOOPS(32), .TOT_CNT_BITS(32), .WORD_BITS(4), .FIFO_DEPTH(2)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .store_response_puf(store),
    .loop_number(loop_number), .loop_response(loop_response), .puf_done(puf_done),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready), .out_last(b_last),
    .busy(b_busy), .seq_error(b_seq), .overflow(b_ovf)
  );

  // Record every accepted word as {last, data}.
  always @(negedge clk) begin
    if (reset && a_valid && a_ready) qa.push_back({a_last, a_data});
    if (reset && b_valid && b_ready) qb.push_back({b_last, b_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    start    = 1'b0;
    store    = 1'b0;
    puf_done = 1'b0;
    idle(2);
    reset = 1'b1;
    qa.delete();
    qb.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    puf_done = 1'b1;
    tick();
    puf_done = 1'b0;
  endtask

  task automatic send_loop(input int idx, input logic [31:0] resp);
    loop_number   = 6'(idx);
    loop_response = resp;
    store         = 1'b1;
    tick();
    store = 1'b0;
  endtask

  // Pair bits 1,0,1,0 | 0,1,0,1 -> words 4'h5, 4'hA; includes equal and MSB-set counts.
  function automatic logic [31:0] mixed_resp(input int i);
    case (i)
      0: return 32'd10;          1: return 32'd20;
      2: return 32'h8000_0000;   3: return 32'd5;
      4: return 32'd0;           5: return 32'd1;
      6: return 32'd77;          7: return 32'd77;
      8: return 32'd300;         9: return 32'd299;
      10: return 32'd1;          11: return 32'hFFFF_FFFF;
      12: return 32'hFFFF_FFFF;  13: return 32'hFFFF_FFFE;
      14: return 32'd5;          default: return 32'd6;
    endcase
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", a_valid); else passes++;
    checks++; if (a_data !== 4'h0) $display("FAIL reset_data: got %h expected 0", a_data); else passes++;
    checks++; if (a_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", a_last); else passes++;
    checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", a_busy); else passes++;
    checks++; if (a_seq !== 1'b0) $display("FAIL reset_seq: got %b expected 0", a_seq); else passes++;
    checks++; if (a_ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", a_ovf); else passes++;
    checks++; if (b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b expected 0", b_valid); else passes++;
    // Strobes and done are ignored while idle.
    send_loop(0, 32'd5);
    send_loop(1, 32'd9);
    pulse_done();
    idle(2);
    checks++; if (a_busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", a_busy); else passes++;
    checks++; if (a_seq !== 1'b0) $display("FAIL idle_seq: got %b expected 0", a_seq); else passes++;
    checks++; if (a_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", a_valid); else passes++;
  endtask

  task automatic test_monotonic();
    do_reset();
    pulse_start();
    checks++; if (a_busy !== 1'b1) $display("FAIL mono_busy_start: got %b expected 1", a_busy); else passes++;
    for (int i = 0; i < 8; i++) send_loop(i, 32'(100 + i));
    checks++; if (a_valid !== 1'b1) $display("FAIL mono_latency_valid: got %b expected 1", a_valid); else passes++;
    checks++; if (a_data !== 4'hF) $display("FAIL mono_latency_data: got %h expected f", a_data); else passes++;
    for (int i = 8; i < 15; i++) send_loop(i, 32'(100 + i));
    checks++; if (a_busy !== 1'b1) $display("FAIL mono_busy_mid: got %b expected 1", a_busy); else passes++;
    send_loop(15, 32'd115);
    checks++; if (a_busy !== 1'b0) $display("FAIL mono_busy_end: got %b expected 0", a_busy); else passes++;
    idle(3);
    checks++; if (qa.size() != 2) $display("FAIL mono_count: got %0d expected 2", qa.size()); else passes++;
    checks++; if (qa.size() < 1 || qa[0] !== 5'h0F) $display("FAIL mono_word0: got %h expected 0f", qa[0]); else passes++;
    checks++; if (qa.size() < 2 || qa[1] !== 5'h1F) $display("FAIL mono_word1: got %h expected 1f", qa[1]); else passes++;
    checks++; if (a_seq !== 1'b0) $display("FAIL mono_seq: got %b expected 0", a_seq); else passes++;
  endtask

  task automatic test_mixed();
    do_reset();
    pulse_start();
    for (int i = 0; i < 16; i++) send_loop(i, mixed_resp(i));
    idle(3);
    checks++; if (qa.size() != 2) $display("FAIL mixed_count: got %0d expected 2", qa.size()); else passes++;
    checks++; if (qa.size() < 1 || qa[0] !== 5'h05) $display("FAIL mixed_word0: got %h expected 05", qa[0]); else passes++;
    checks++; if (qa.size() < 2 || qa[1] !== 5'h1A) $display("FAIL mixed_word1: got %h expected 1a", qa[1]); else passes++;
  endtask

  task automatic test_seq_fault();
    do_reset();
    pulse_start();
    send_loop(1, 32'd50);
    checks++; if (a_seq !== 1'b1) $display("FAIL seq_wait_a: got %b expected 1", a_seq); else passes++;
    checks++; if (a_busy !== 1'b1) $display("FAIL seq_busy: got %b expected 1", a_busy); else passes++;
    // Wrong B index drops the latched A count and waits for loop 0 again.
    send_loop(0, 32'd500);
    send_loop(3, 32'd10);
    for (int i = 0; i < 16; i++) send_loop(i, 32'(100 + i));
    idle(3);
    checks++; if (qa.size() != 2) $display("FAIL seq_count: got %0d expected 2", qa.size()); else passes++;
    checks++; if (qa.size() < 1 || qa[0] !== 5'h0F) $display("FAIL seq_word0: got %h expected 0f", qa[0]); else passes++;
    checks++; if (qa.size() < 2 || qa[1] !== 5'h1F) $display("FAIL seq_word1: got %h expected 1f", qa[1]); else passes++;
    checks++; if (a_seq !== 1'b1) $display("FAIL seq_sticky: got %b expected 1", a_seq); else passes++;
  endtask

  task automatic test_early_done();
    do_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) send_loop(i, 32'(100 + i));
    pulse_done();
    checks++; if (a_busy !== 1'b1) $display("FAIL early_flush_busy: got %b expected 1", a_busy); else passes++;
    idle(3);
    checks++; if (qa.size() != 1) $display("FAIL early_count: got %0d expected 1", qa.size()); else passes++;
    checks++; if (qa.size() < 1 || qa[0] !== 5'h17) $display("FAIL early_word: got %h expected 17", qa[0]); else passes++;
    checks++; if (a_seq !== 1'b1) $display("FAIL early_seq: got %b expected 1", a_seq); else passes++;
    checks++; if (a_busy !== 1'b0) $display("FAIL early_busy: got %b expected 0", a_busy); else passes++;
  endtask

  task automatic test_overflow();
    logic [15:0] pat;
    pat = 16'h4321;
    do_reset();
    b_ready = 1'b0;
    pulse_start();
    for (int p = 0; p < 16; p++) begin
      send_loop(2 * p, 32'd200);
      send_loop(2 * p + 1, pat[p] ? 32'd201 : 32'd200);
      if (p == 7) begin
        checks++; if (b_data !== 4'h1) $display("FAIL ovf_hold_mid: got %h expected 1", b_data); else passes++;
      end
    end
    checks++; if (b_valid !== 1'b1) $display("FAIL ovf_valid: got %b expected 1", b_valid); else passes++;
    checks++; if (b_data !== 4'h1) $display("FAIL ovf_hold_data: got %h expected 1", b_data); else passes++;
    checks++; if (b_last !== 1'b0) $display("FAIL ovf_hold_last: got %b expected 0", b_last); else passes++;
    checks++; if (b_ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", b_ovf); else passes++;
    // Start is ignored while undelivered words remain.
    pulse_start();
    checks++; if (b_busy !== 1'b0) $display("FAIL ovf_start_ignored: got %b expected 0", b_busy); else passes++;
    checks++; if (b_ovf !== 1'b1) $display("FAIL ovf_kept: got %b expected 1", b_ovf); else passes++;
    b_ready = 1'b1;
    idle(4);
    checks++; if (qb.size() != 2) $display("FAIL ovf_count: got %0d expected 2", qb.size()); else passes++;
    checks++; if (qb.size() < 1 || qb[0] !== 5'h01) $display("FAIL ovf_word0: got %h expected 01", qb[0]); else passes++;
    checks++; if (qb.size() < 2 || qb[1] !== 5'h02) $display("FAIL ovf_word1: got %h expected 02", qb[1]); else passes++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    pulse_start();
    send_loop(3, 32'd1);
    for (int i = 0; i < 7; i++) send_loop(i, 32'(100 + i));
    checks++; if (a_seq !== 1'b1) $display("FAIL rst_pre_seq: got %b expected 1", a_seq); else passes++;
    reset = 1'b0;
    tick();
    checks++; if (a_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", a_busy); else passes++;
    checks++; if (a_seq !== 1'b0) $display("FAIL rst_seq: got %b expected 0", a_seq); else passes++;
    checks++; if (a_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", a_valid); else passes++;
    checks++; if (a_data !== 4'h0) $display("FAIL rst_data: got %h expected 0", a_data); else passes++;
    reset = 1'b1;
    qa.delete();
    pulse_start();
    for (int i = 0; i < 16; i++) send_loop(i, mixed_resp(i));
    idle(3);
    checks++; if (qa.size() != 2) $display("FAIL rst_count: got %0d expected 2", qa.size()); else passes++;
    checks++; if (qa.size() < 1 || qa[0] !== 5'h05) $display("FAIL rst_word0: got %h expected 05", qa[0]); else passes++;
    checks++; if (qa.size() < 2 || qa[1] !== 5'h1A) $display("FAIL rst_word1: got %h expected 1a", qa[1]); else passes++;
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    store         = 1'b0;
    puf_done      = 1'b0;
    loop_number   = '0;
    loop_response = '0;
    a_ready       = 1'b1;
    b_ready       = 1'b1;
    test_reset();
    test_monotonic();
    test_mixed();
    test_seq_fault();
    test_early_done();
    test_overflow();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
